tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Shared timebase and timeout scheduler for the lock datapath. One prescaler divides Clk_100M into a periodic tick plus a 50 % slow_clk. That slow_clk is cycle-for-cycle identical to the existing divider output, so display scanning is unaffected. NUM_CH independent countdown channels share the tick and serve keypad debounce, display scan, wrong-code lockout and unlock-hold timing, each started/stopped by its owner and signalling expiry with a one-cycle pulse.

## Interface
- TICK_DIV, 250000: Clk_100M cycles per tick (400 Hz at 100 MHz); must be ≥ 2 and even.
- NUM_CH, 4: number of countdown channels.
- CNT_W, 16: width of each channel's load/remaining counter.
- Clk_100M  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronous to Clk_100M upstream.
- start  in  NUM_CH  per-channel one-cycle start/restart request.
- stop  in  NUM_CH  per-channel one-cycle abort request.
- periodic  in  NUM_CH  per-channel mode, sampled at start: 1 = auto-reload, 0 = one-shot.
- load_val  in  NUM_CH*CNT_W  per-channel period in ticks, channel i at bits [i*CNT_W +: CNT_W], sampled at start.
- tick  out  1  one-cycle pulse every TICK_DIV cycles.
- slow_clk  out  1  square wave, period TICK_DIV cycles, low first half.
- busy  out  NUM_CH  channel counting.
- expire  out  NUM_CH  one-cycle expiry pulse.

## Operation
- Prescaler: pre_cnt counts 0..TICK_DIV-1 then wraps to 0. Registered tick = 1 for the cycle after pre_cnt == TICK_DIV-1. Registered slow_clk = (pre_cnt ≥ TICK_DIV/2).
- Per-channel FSM, states IDLE, RUN:
  - IDLE: on start with load_val ≠ 0, latch remaining = load_val and mode = periodic, go to RUN. On start with load_val == 0, pulse expire next cycle and stay IDLE (busy stays 0).
  - RUN, on tick with remaining > 1: decrement remaining.
  - RUN, on tick with remaining == 1: pulse expire. If mode = periodic, reload remaining = latched period and stay in RUN; otherwise go to IDLE.
  - RUN, on start: restart. Reload from the current load_val/periodic; the pending tick in that cycle is ignored.
  - stop in any state: go to IDLE, remaining = 0, no expire. stop wins over start and over tick in the same cycle.
- busy = (state == RUN), registered.
- Channels are fully independent; simultaneous expiries on several channels all pulse in the same cycle.
- Arithmetic: remaining is unsigned CNT_W bits and never decrements below 1 in RUN. The period register holds the sampled load_val for reload.

## Timing
- Reset values: pre_cnt 0, tick 0, slow_clk 0, all channels IDLE, remaining 0, busy 0, expire 0. Reset mid-count aborts everything with no expire pulse.
- start → busy = 1 in the next cycle.
- First decrement happens on the first tick strictly after the start cycle. One-shot expiry therefore lands between (N-1)*TICK_DIV+1 and N*TICK_DIV cycles after start for load_val N; channels are not phase-aligned to start.
- expire asserts the cycle after the qualifying tick cycle and lasts exactly 1 cycle. In one-shot mode busy falls in that same cycle.
- Periodic mode: expire pulses exactly N*TICK_DIV cycles apart.
- The prescaler free-runs and is never reset by channel activity.

## Structure
- Package tick_sched_pkg holds:
  - channel state enum (IDLE, RUN);
  - default constants TICK_DIV_DEF = 250000, CNT_W_DEF = 16;
  - channel index constants CH_DEBOUNCE = 0, CH_SCAN = 1, CH_LOCKOUT = 2, CH_HOLD = 3.
- Sub-module tick_channel holds one FSM, remaining and period registers, and the expire/busy flops. The top instantiates NUM_CH copies via generate and owns the prescaler.
- pre_cnt width is $clog2(TICK_DIV).

## Test plan
All scenarios use TICK_DIV = 10, CNT_W = 8.
- Reset/free-run: release rst_n. Expect tick every 10 cycles and slow_clk 0 for 5 cycles then 1 for 5. Assert rst_n low mid-period: pre_cnt, tick and slow_clk go to 0 immediately.
- One-shot: start ch0 with load_val = 3, periodic = 0. Expect exactly one expire[0] pulse 21–30 cycles after start, busy[0] high until that cycle, then IDLE.
- Periodic: start ch1 with load_val = 2, periodic = 1. Expect expire[1] pulses exactly 20 cycles apart ×5 and busy[1] held 1. Then stop ch1: busy drops next cycle, no further expire.
- Corner loads: start ch2 with load_val = 0: one expire pulse next cycle, busy never 1. load_val = 255: 255 ticks elapse before expire.
- Simultaneous events: start and stop on ch3 in the same cycle → stays IDLE. stop coinciding with a final tick → no expire. Restart mid-run with load_val = 4 → expire counted from the restart.
- Concurrency: all 4 channels started in the same cycle with load_val = 2 → all expire bits pulse in the same cycle.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// tick_sched_pkg: shared channel state type, default sizing and channel role indices.
package tick_sched_pkg;
    typedef enum logic {IDLE, RUN} ch_state_e;
    localparam int TICK_DIV_DEF = 250000;
    localparam int CNT_W_DEF    = 16;
    localparam int CH_DEBOUNCE  = 0;
    localparam int CH_SCAN      = 1;
    localparam int CH_LOCKOUT   = 2;
    localparam int CH_HOLD      = 3;
endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: channel control requests from owners and timebase/status back to them.
interface tick_scheduler_if
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH-1:0]       periodic;
    logic [NUM_CH*CNT_W-1:0] load_val;
    logic                    tick;
    logic                    slow_clk;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expire;
    modport master (output start, stop, periodic, load_val, input tick, slow_clk, busy, expire);
    modport slave  (input start, stop, periodic, load_val, output tick, slow_clk, busy, expire);
endinterface

// File: rtl/tick_scheduler_channel.sv
// tick_channel: one countdown channel clocked by the shared tick, pulsing expire at zero.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             expire_o
);
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d, per_q, per_d;
    logic             mode_q, mode_d, expire_q, expire_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            per_q    <= '0;
            mode_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            per_q    <= per_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end
    // stop beats start, and start beats a coincident tick
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        per_d    = per_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        if (stop_i) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (start_i) begin
            state_d  = (load_val_i != '0) ? RUN : IDLE;
            rem_d    = load_val_i;
            per_d    = load_val_i;
            mode_d   = periodic_i;
            expire_d = (load_val_i == '0);
        end else if (state_q == RUN && tick_i) begin
            if (rem_q == CNT_W'(1)) begin
                expire_d = 1'b1;
                rem_d    = mode_q ? per_q : '0;
                state_d  = mode_q ? RUN : IDLE;
            end else begin
                rem_d = rem_q - CNT_W'(1);
            end
        end
    end
    assign busy_o   = (state_q == RUN);
    assign expire_o = expire_q;
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: free-running prescaler producing tick/slow_clk, shared by NUM_CH countdown channels.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic         Clk_100M,
    input  logic         rst_n,
    tick_scheduler_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic          tick_q, slow_clk_q;
    assign pre_cnt_d = (pre_cnt_q == PW'(TICK_DIV - 1)) ? '0 : pre_cnt_q + PW'(1);
    // slow_clk registered from the same count so it stays in step with the legacy divider
    always_ff @(posedge Clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q  <= '0;
            tick_q     <= 1'b0;
            slow_clk_q <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            tick_q     <= (pre_cnt_q == PW'(TICK_DIV - 1));
            slow_clk_q <= (pre_cnt_q >= PW'(TICK_DIV / 2));
        end
    end
    assign bus.tick     = tick_q;
    assign bus.slow_clk = slow_clk_q;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tick_channel #(.CNT_W(CNT_W)) u_ch (
            .clk        (Clk_100M),
            .rst_n      (rst_n),
            .tick_i     (tick_q),
            .start_i    (bus.start[c]),
            .stop_i     (bus.stop[c]),
            .periodic_i (bus.periodic[c]),
            .load_val_i (bus.load_val[c*CNT_W +: CNT_W]),
            .busy_o     (bus.busy[c]),
            .expire_o   (bus.expire[c])
        );
    end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed scenarios checked every cycle against a schedule-based expiry model.
module tb_tick_scheduler;
    import tick_sched_pkg::*;
    localparam int TD = 10;
    localparam int NC = 4;
    localparam int CW = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    tick_scheduler_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();
    tick_scheduler #(.TICK_DIV(TD), .NUM_CH(NC), .CNT_W(CW)) dut (
        .Clk_100M (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );
    int checks = 0;
    int fails  = 0;
    int e = 0;
    bit act [NC];
    bit mode [NC];
    int nxt [NC];
    int per [NC];
    int m_n;
    logic [NC-1:0] m_busy, m_exp;
    int exp_cnt [NC];
    int last_exp [NC];
    int intv [NC];
    int tick_seen = 0;
    int slow_hi = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, want, e);
        end
    endtask
    // Model: each start schedules an absolute expiry edge from the tick grid (ticks act at edges 10k+1)
    always @(posedge clk) begin
        if (!rst_n) begin
            e = 0;
            for (int i = 0; i < NC; i++) act[i] = 1'b0;
            m_busy = '0;
            m_exp = '0;
        end else begin
            e++;
            for (int i = 0; i < NC; i++) begin
                m_n = int'(bus.load_val[i*CW +: CW]);
                m_exp[i] = 1'b0;
                if (bus.stop[i]) act[i] = 1'b0;
                else if (bus.start[i]) begin
                    if (m_n == 0) begin
                        m_exp[i] = 1'b1;
                        act[i] = 1'b0;
                    end else begin
                        act[i] = 1'b1;
                        per[i] = m_n;
                        mode[i] = bus.periodic[i];
                        nxt[i] = ((e + TD - 1) / TD) * TD + TD * (m_n - 1) + 1;
                    end
                end else if (act[i] && e == nxt[i]) begin
                    m_exp[i] = 1'b1;
                    if (mode[i]) nxt[i] += TD * per[i];
                    else act[i] = 1'b0;
                end
                m_busy[i] = act[i];
            end
            #1;
            chk("tick", bus.tick, (e % TD) == 0);
            chk("slow_clk", bus.slow_clk, ((e % TD) == 0) || ((e % TD) > TD / 2));
            chk("busy", bus.busy, m_busy);
            chk("expire", bus.expire, m_exp);
            if (bus.tick) tick_seen++;
            if (bus.slow_clk) slow_hi++;
            for (int i = 0; i < NC; i++) if (bus.expire[i]) begin
                if (exp_cnt[i] > 0) intv[i] = e - last_exp[i];
                last_exp[i] = e;
                exp_cnt[i]++;
            end
        end
    end
    task automatic drive(input logic [NC-1:0] st, input logic [NC-1:0] sp, input logic [NC-1:0] pm,
                         input logic [NC*CW-1:0] ld, output int s);
        bus.start = st;
        bus.stop = sp;
        bus.periodic = pm;
        bus.load_val = ld;
        s = e + 1;
        @(negedge clk);
        bus.start = '0;
        bus.stop = '0;
    endtask
    task automatic wait_cnt(input int ch, input int target, input int budget);
        for (int k = 0; k < budget && exp_cnt[ch] < target; k++) @(negedge clk);
    endtask
    int s, d, base [NC];
    initial begin
        bus.start = '0;
        bus.stop = '0;
        bus.periodic = '0;
        bus.load_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_tick", bus.tick, 0);
        chk("rst_slow", bus.slow_clk, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_expire", bus.expire, 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("tick_count_50", tick_seen, 5);
        chk("slow_high_50", slow_hi, 25);
        drive(4'b0001, 4'b0000, 4'b0000, 32'h0000_0003, s);
        wait_cnt(0, 1, 40);
        repeat (10) @(negedge clk);
        d = last_exp[0] - s;
        chk("oneshot_count", exp_cnt[0], 1);
        chk("oneshot_delay_21_30", (d >= 21 && d <= 30), 1);
        drive(4'b0010, 4'b0000, 4'b0010, 32'h0000_0200, s);
        for (int p = 1; p <= 5; p++) begin
            wait_cnt(1, p, 30);
            chk("periodic_count", exp_cnt[1], p);
            if (p > 1) chk("periodic_interval", intv[1], 20);
            chk("periodic_busy", bus.busy[1], 1);
        end
        drive(4'b0000, 4'b0010, 4'b0000, 32'h0, s);
        chk("periodic_stop_busy", bus.busy[1], 0);
        repeat (50) @(negedge clk);
        chk("periodic_stop_quiet", exp_cnt[1], 5);
        drive(4'b0100, 4'b0000, 4'b0000, 32'h0000_0000, s);
        chk("zero_load_count", exp_cnt[2], 1);
        chk("zero_load_cycle", last_exp[2], s);
        chk("zero_load_busy", bus.busy[2], 0);
        drive(4'b0100, 4'b0000, 4'b0000, 32'h00FF_0000, s);
        wait_cnt(2, 2, 2600);
        d = last_exp[2] - s;
        chk("load255_count", exp_cnt[2], 2);
        chk("load255_delay", (d >= 2541 && d <= 2550), 1);
        drive(4'b1000, 4'b1000, 4'b0000, 32'h0500_0000, s);
        repeat (3) @(negedge clk);
        chk("start_stop_busy", bus.busy[3], 0);
        chk("start_stop_count", exp_cnt[3], 0);
        drive(4'b1000, 4'b0000, 4'b0000, 32'h0100_0000, s);
        for (int k = 0; k < 30 && e != nxt[3] - 1; k++) @(negedge clk);
        chk("stop_on_tick_aligned", bus.tick, 1);
        drive(4'b0000, 4'b1000, 4'b0000, 32'h0, s);
        repeat (30) @(negedge clk);
        chk("stop_on_tick_no_expire", exp_cnt[3], 0);
        drive(4'b1000, 4'b0000, 4'b0000, 32'h0900_0000, s);
        repeat (35) @(negedge clk);
        drive(4'b1000, 4'b0000, 4'b0000, 32'h0400_0000, s);
        repeat (60) @(negedge clk);
        d = last_exp[3] - s;
        chk("restart_count", exp_cnt[3], 1);
        chk("restart_delay", (d >= 31 && d <= 40), 1);
        for (int i = 0; i < NC; i++) base[i] = exp_cnt[i];
        drive(4'b1111, 4'b0000, 4'b0000, 32'h0202_0202, s);
        wait_cnt(0, base[0] + 1, 30);
        repeat (2) @(negedge clk);
        d = last_exp[0] - s;
        chk("concurrent_delay", (d >= 11 && d <= 20), 1);
        for (int i = 0; i < NC; i++) begin
            chk("concurrent_count", exp_cnt[i], base[i] + 1);
            chk("concurrent_same_cycle", last_exp[i], last_exp[0]);
        end
        drive(4'b0001, 4'b0000, 4'b0001, 32'h0000_0003, s);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 20 && !bus.slow_clk; k++) @(negedge clk);
        chk("pre_reset_slow_high", bus.slow_clk, 1);
        chk("pre_reset_busy", bus.busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tick", bus.tick, 0);
        chk("async_rst_slow", bus.slow_clk, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_expire", bus.expire, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base[0] = exp_cnt[0];
        repeat (40) @(negedge clk);
        chk("post_reset_no_expire", exp_cnt[0], base[0]);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
